// File: rtl/uart_pi1_arb_pkg.sv
// Shared pi1 bus definitions for the uart_hw device and its two-port arbiter.
// Op encodings, arbiter state encoding and a request helper.
package uart_pi1_arb_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    localparam int LOCKCNTW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    function automatic logic pi_req(input logic [1:0] op);
        return op != PINOOP;
    endfunction

endpackage

// File: rtl/uart_pi1_arb.sv
// Two-requester pi1 arbiter in front of uart_hw.
// Round-robin pick with a bounded lock that lets one master keep the port.
module uart_pi1_arb
    import uart_pi1_arb_pkg::*;
#(
    parameter int ARCHBITSZ = 32,
    parameter int LOCKMAX   = 16,
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8),
    localparam int SELBITSZ  = ARCHBITSZ / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic [1:0]           m0_op_i,
    input  logic [ADDRBITSZ-1:0] m0_addr_i,
    input  logic [ARCHBITSZ-1:0] m0_data_i,
    input  logic [SELBITSZ-1:0]  m0_sel_i,
    input  logic                 m0_lock_i,
    output logic [ARCHBITSZ-1:0] m0_data_o,
    output logic                 m0_rdy_o,

    input  logic [1:0]           m1_op_i,
    input  logic [ADDRBITSZ-1:0] m1_addr_i,
    input  logic [ARCHBITSZ-1:0] m1_data_i,
    input  logic [SELBITSZ-1:0]  m1_sel_i,
    input  logic                 m1_lock_i,
    output logic [ARCHBITSZ-1:0] m1_data_o,
    output logic                 m1_rdy_o,

    output logic [1:0]           s_op_o,
    output logic [ADDRBITSZ-1:0] s_addr_o,
    output logic [ARCHBITSZ-1:0] s_data_o,
    output logic [SELBITSZ-1:0]  s_sel_o,
    input  logic [ARCHBITSZ-1:0] s_data_i,
    input  logic                 s_rdy_i
);

    localparam logic [LOCKCNTW-1:0] LOCKCAP = LOCKCNTW'(LOCKMAX);

    arb_state_e state_q, state_d;

    logic [1:0]           op_q, op_d;
    logic [ADDRBITSZ-1:0] addr_q, addr_d;
    logic [ARCHBITSZ-1:0] data_q, data_d;
    logic [SELBITSZ-1:0]  sel_q, sel_d;
    logic                 lock_q, lock_d;

    // g_q is the current grant while busy and the last grant while idle
    logic                 g_q, g_d;
    logic [LOCKCNTW-1:0]  lockcnt_q, lockcnt_d;
    logic                 lockpend_q, lockpend_d;

    logic [ARCHBITSZ-1:0] m0_data_q, m0_data_d;
    logic [ARCHBITSZ-1:0] m1_data_q, m1_data_d;

    logic req0;
    logic req1;
    logic req_last;
    logic lock_hit;
    logic win;

    assign req0     = pi_req(m0_op_i);
    assign req1     = pi_req(m1_op_i);
    assign req_last = g_q ? req1 : req0;
    assign lock_hit = lockpend_q && req_last
                   && (lockcnt_q < LOCKCAP);

    // Lock beats round-robin; otherwise the master not served last wins
    always_comb begin
        win = req1;
        if (lock_hit) begin
            win = g_q;
        end else if (req0 && req1) begin
            win = ~g_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        sel_d      = sel_q;
        lock_d     = lock_q;
        g_d        = g_q;
        lockcnt_d  = lockcnt_q;
        lockpend_d = lockpend_q;
        m0_data_d  = m0_data_q;
        m1_data_d  = m1_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_ISSUE;
                    g_d     = win;
                    if (lock_hit) begin
                        lockcnt_d = lockcnt_q + 1'b1;
                    end else begin
                        lockcnt_d = '0;
                    end
                    if (win) begin
                        op_d   = m1_op_i;
                        addr_d = m1_addr_i;
                        data_d = m1_data_i;
                        sel_d  = m1_sel_i;
                        lock_d = m1_lock_i;
                    end else begin
                        op_d   = m0_op_i;
                        addr_d = m0_addr_i;
                        data_d = m0_data_i;
                        sel_d  = m0_sel_i;
                        lock_d = m0_lock_i;
                    end
                end
            end

            ST_ISSUE: begin
                if (s_rdy_i) begin
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                state_d    = ST_IDLE;
                lockpend_d = lock_q;
                if (g_q) begin
                    m1_data_d = s_data_i;
                end else begin
                    m0_data_d = s_data_i;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            op_q       <= PINOOP;
            addr_q     <= '0;
            data_q     <= '0;
            sel_q      <= '0;
            lock_q     <= 1'b0;
            g_q        <= 1'b1;
            lockcnt_q  <= '0;
            lockpend_q <= 1'b0;
            m0_data_q  <= '0;
            m1_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            lock_q     <= lock_d;
            g_q        <= g_d;
            lockcnt_q  <= lockcnt_d;
            lockpend_q <= lockpend_d;
            m0_data_q  <= m0_data_d;
            m1_data_q  <= m1_data_d;
        end
    end

    assign s_op_o   = (state_q == ST_ISSUE) ? op_q : PINOOP;
    assign s_addr_o = addr_q;
    assign s_data_o = data_q;
    assign s_sel_o  = sel_q;

    assign m0_rdy_o = (state_q == ST_RESP) && !g_q;
    assign m1_rdy_o = (state_q == ST_RESP) && g_q;

    // Response word is forwarded in the RESP cycle, then held
    assign m0_data_o = m0_rdy_o ? s_data_i : m0_data_q;
    assign m1_data_o = m1_rdy_o ? s_data_i : m1_data_q;

endmodule

// File: tb/tb_uart_pi1_arb.sv
// Self-checking bench for uart_pi1_arb: vector table, corner sequences
// and a randomized run against a transaction-level arbitration model.
module tb_uart_pi1_arb;
    import uart_pi1_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 30;
    localparam int SW = 4;
    localparam int LOCKMAX = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [1:0]    m0_op_i, m1_op_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_data_i, m1_data_i;
    logic [SW-1:0] m0_sel_i, m1_sel_i;
    logic          m0_lock_i, m1_lock_i;
    logic [DW-1:0] m0_data_o, m1_data_o;
    logic          m0_rdy_o, m1_rdy_o;
    logic [1:0]    s_op_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_data_o;
    logic [SW-1:0] s_sel_o;
    logic [DW-1:0] s_data_i;
    logic          s_rdy_i;

    uart_pi1_arb #(.ARCHBITSZ(DW), .LOCKMAX(LOCKMAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_op_i(m0_op_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i),
        .m0_lock_i(m0_lock_i), .m0_data_o(m0_data_o),
        .m0_rdy_o(m0_rdy_o),
        .m1_op_i(m1_op_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i),
        .m1_lock_i(m1_lock_i), .m1_data_o(m1_data_o),
        .m1_rdy_o(m1_rdy_o),
        .s_op_o(s_op_o), .s_addr_o(s_addr_o),
        .s_data_o(s_data_o), .s_sel_o(s_sel_o),
        .s_data_i(s_data_i), .s_rdy_i(s_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        m0_op_i = PINOOP; m0_addr_i = '0; m0_data_i = '0;
        m0_sel_i = '0; m0_lock_i = 1'b0;
        m1_op_i = PINOOP; m1_addr_i = '0; m1_data_i = '0;
        m1_sel_i = '0; m1_lock_i = 1'b0;
    endtask

    // Leaves the bench in cycle 0: DUT idle, reset released
    task automatic do_reset();
        rst_i = 1'b0;
        idle_inputs();
        s_rdy_i = 1'b1;
        s_data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    typedef struct {
        logic [1:0]    op0;
        logic [1:0]    op1;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [SW-1:0] s0;
        logic [SW-1:0] s1;
        logic [DW-1:0] sdat;
        logic          g;
        logic [1:0]    eop;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edata;
        logic [SW-1:0] esel;
    } vec_t;

    vec_t vt [5];

    // Transaction-level model state for the random run
    localparam int PH_ARB = 0;
    localparam int PH_ISS = 1;
    localparam int PH_RSP = 2;
    int            phase;
    bit            lpend;
    int            lcnt;
    bit            last;
    bit            w;
    logic [1:0]    ex_op;
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_data;
    logic [SW-1:0] ex_sel;
    bit            ex_lock;
    logic [DW-1:0] mdl_data [2];
    bit            mact [2];
    logic [1:0]    mop [2];
    logic [AW-1:0] madr [2];
    logic [DW-1:0] mdat [2];
    logic [SW-1:0] msel [2];
    bit            mlck [2];

    function automatic logic [DW-1:0] dout(input bit k);
        return k ? m1_data_o : m0_data_o;
    endfunction

    function automatic logic rdy(input bit k);
        return k ? m1_rdy_o : m0_rdy_o;
    endfunction

    task automatic drive_masters();
        m0_op_i = mop[0]; m0_addr_i = madr[0]; m0_data_i = mdat[0];
        m0_sel_i = msel[0]; m0_lock_i = mlck[0];
        m1_op_i = mop[1]; m1_addr_i = madr[1]; m1_data_i = mdat[1];
        m1_sel_i = msel[1]; m1_lock_i = mlck[1];
    endtask

    task automatic model_pick();
        bit r0;
        bit r1;
        bit rl;
        r0 = (m0_op_i != PINOOP);
        r1 = (m1_op_i != PINOOP);
        rl = last ? r1 : r0;
        if (lpend && rl && lcnt < LOCKMAX) begin
            w = last;
            lcnt++;
        end else begin
            w = (r0 && r1) ? !last : r1;
            lcnt = 0;
        end
        last = w;
        ex_op   = w ? m1_op_i   : m0_op_i;
        ex_addr = w ? m1_addr_i : m0_addr_i;
        ex_data = w ? m1_data_i : m0_data_i;
        ex_sel  = w ? m1_sel_i  : m0_sel_i;
        ex_lock = w ? m1_lock_i : m0_lock_i;
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!(phase == PH_RSP && w == k[0]))
                chk("rnd_hold_data", dout(k[0]), mdl_data[k]);
        end
        case (phase)
            PH_ARB: begin
                chk("rnd_idle_op", s_op_o, PINOOP);
                chk("rnd_idle_rdy", {m1_rdy_o, m0_rdy_o}, 2'b00);
                if (m0_op_i != PINOOP || m1_op_i != PINOOP) begin
                    model_pick();
                    phase = PH_ISS;
                end
            end
            PH_ISS: begin
                chk("rnd_op", s_op_o, ex_op);
                chk("rnd_addr", s_addr_o, ex_addr);
                chk("rnd_data", s_data_o, ex_data);
                chk("rnd_sel", s_sel_o, ex_sel);
                chk("rnd_iss_rdy", {m1_rdy_o, m0_rdy_o}, 2'b00);
                if (s_rdy_i) phase = PH_RSP;
            end
            default: begin
                chk("rnd_rsp_op", s_op_o, PINOOP);
                chk("rnd_rdy_win", rdy(w), 1'b1);
                chk("rnd_rdy_lose", rdy(!w), 1'b0);
                chk("rnd_resp_data", dout(w), s_data_i);
                mdl_data[w] = s_data_i;
                lpend = ex_lock;
                mact[w] = 1'b0;
                phase = PH_ARB;
            end
        endcase
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int m1_done;
    bit m0_done;
    int m1_before;

    initial begin
        vt[0] = '{PIRDOP, PINOOP, 30'h10, 30'h0, 32'h1111, 32'h0,
                  4'hf, 4'h0, 32'h41, 1'b0, PIRDOP, 30'h10,
                  32'h1111, 4'hf};
        vt[1] = '{PINOOP, PIWROP, 30'h0, 30'h22, 32'h0, 32'h2222,
                  4'h0, 4'h3, 32'h5, 1'b1, PIWROP, 30'h22,
                  32'h2222, 4'h3};
        vt[2] = '{PIRWOP, PIRWOP, 30'h33, 30'h44, 32'h3333, 32'h4444,
                  4'h1, 4'h2, 32'h77, 1'b0, PIRWOP, 30'h33,
                  32'h3333, 4'h1};
        vt[3] = '{PIWROP, PIRDOP, 30'h3fffffff, 30'h1, 32'hffffffff,
                  32'h1, 4'h8, 4'h4, 32'h0, 1'b0, PIWROP,
                  30'h3fffffff, 32'hffffffff, 4'h8};
        vt[4] = '{PINOOP, PIRWOP, 30'h5, 30'h0, 32'h9, 32'h0,
                  4'h6, 4'hc, 32'hffffffff, 1'b1, PIRWOP, 30'h0,
                  32'h0, 4'hc};

        do_reset();
        sample();
        chk("rst_op", s_op_o, PINOOP);
        chk("rst_rdy", {m1_rdy_o, m0_rdy_o}, 2'b00);
        chk("rst_m0_data", m0_data_o, 0);
        chk("rst_m1_data", m1_data_o, 0);
        chk("rst_capture", {s_addr_o, s_data_o, s_sel_o}, 0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            m0_op_i = vt[i].op0; m0_addr_i = vt[i].a0;
            m0_data_i = vt[i].d0; m0_sel_i = vt[i].s0;
            m1_op_i = vt[i].op1; m1_addr_i = vt[i].a1;
            m1_data_i = vt[i].d1; m1_sel_i = vt[i].s1;
            s_data_i = vt[i].sdat;
            sample();
            chk("vec_c0_op", s_op_o, PINOOP);
            next_cycle();
            sample();
            chk("vec_op", s_op_o, vt[i].eop);
            chk("vec_addr", s_addr_o, vt[i].eaddr);
            chk("vec_data", s_data_o, vt[i].edata);
            chk("vec_sel", s_sel_o, vt[i].esel);
            chk("vec_c1_rdy", {m1_rdy_o, m0_rdy_o}, 2'b00);
            next_cycle();
            sample();
            chk("vec_m0_rdy", m0_rdy_o, !vt[i].g);
            chk("vec_m1_rdy", m1_rdy_o, vt[i].g);
            chk("vec_resp", dout(vt[i].g), vt[i].sdat);
            chk("vec_other", dout(!vt[i].g), 0);
        end

        do_reset();
        m0_op_i = PIRWOP; m0_addr_i = 30'h1;
        m1_op_i = PIRWOP; m1_addr_i = 30'h2;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle();
            sample();
            chk("rr_m0_rdy", m0_rdy_o, (c == 2 || c == 8));
            chk("rr_m1_rdy", m1_rdy_o, (c == 5));
            if (c == 1 || c == 7) chk("rr_addr_m0", s_addr_o, 1);
            if (c == 4) chk("rr_addr_m1", s_addr_o, 2);
        end

        do_reset();
        m1_op_i = PIWROP; m1_addr_i = 30'h100; m1_lock_i = 1'b1;
        m1_done = 0; m0_done = 1'b0; m1_before = -1;
        for (int c = 0; c < 300; c++) begin
            if (c > 0) begin
                next_cycle();
                m0_op_i = m0_done ? PINOOP : PIRDOP;
                m1_op_i = (m1_done < 20) ? PIWROP : PINOOP;
                m1_data_i = DW'(m1_done);
            end
            sample();
            if (m1_rdy_o) m1_done++;
            if (m0_rdy_o) begin
                m0_done = 1'b1;
                m1_before = m1_done;
            end
            if (m1_done >= 20 && m0_done) break;
        end
        chk("lock_regrants", m1_before - 1, LOCKMAX);
        chk("lock_m0_served", m0_done, 1'b1);
        chk("lock_m1_total", m1_done, 20);

        do_reset();
        m0_op_i = PIRDOP; m0_addr_i = 30'h55; s_rdy_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                next_cycle();
                s_rdy_i = (c >= 5);
                s_data_i = (c == 6) ? 32'h99 : 32'h0;
                m0_op_i = (c <= 6) ? PIRDOP : PINOOP;
            end
            sample();
            if (c >= 1 && c <= 5) chk("bp_op_held", s_op_o, PIRDOP);
            else chk("bp_op_noop", s_op_o, PINOOP);
            chk("bp_rdy", m0_rdy_o, (c == 6));
            if (c >= 6) chk("bp_data", m0_data_o, 32'h99);
        end

        do_reset();
        m0_op_i = PIRDOP; m0_addr_i = 30'h77; s_rdy_i = 1'b0;
        next_cycle();
        sample();
        chk("rmid_issue", s_op_o, PIRDOP);
        next_cycle();
        rst_i = 1'b0;
        next_cycle();
        rst_i = 1'b1;
        m0_op_i = PINOOP;
        m1_op_i = PIWROP; m1_addr_i = 30'h88; m1_data_i = 32'habc;
        s_rdy_i = 1'b1;
        sample();
        chk("rmid_op", s_op_o, PINOOP);
        chk("rmid_rdy", {m1_rdy_o, m0_rdy_o}, 2'b00);
        chk("rmid_addr", s_addr_o, 0);
        next_cycle();
        sample();
        chk("rmid_m1_op", s_op_o, PIWROP);
        chk("rmid_m1_addr", s_addr_o, 30'h88);
        next_cycle();
        s_data_i = 32'h5a5a;
        sample();
        chk("rmid_m1_rdy", m1_rdy_o, 1'b1);
        chk("rmid_m0_rdy", m0_rdy_o, 1'b0);
        chk("rmid_m1_data", m1_data_o, 32'h5a5a);

        do_reset();
        m0_op_i = PIWROP; m0_addr_i = 30'h123;
        m0_data_i = 32'hdead; m0_sel_i = 4'h3; s_rdy_i = 1'b0;
        for (int c = 1; c < 7; c++) begin
            next_cycle();
            if (c == 1) begin
                m0_addr_i = 30'h456;
                m0_data_i = 32'hbeef;
            end
            s_rdy_i = (c >= 2);
            sample();
            if (c <= 3) begin
                chk("chg_addr", s_addr_o, 30'h123);
                chk("chg_data", s_data_o, 32'hdead);
                chk("chg_sel", s_sel_o, 4'h3);
            end
            chk("chg_rdy", m0_rdy_o, (c == 3 || c == 6));
            if (c == 5) begin
                chk("chg_new_op", s_op_o, PIWROP);
                chk("chg_new_addr", s_addr_o, 30'h456);
            end
        end

        do_reset();
        phase = PH_ARB; lpend = 1'b0; lcnt = 0; last = 1'b1; w = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mdl_data[k] = '0; mact[k] = 1'b0; mop[k] = PINOOP;
            madr[k] = '0; mdat[k] = '0; msel[k] = '0; mlck[k] = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) next_cycle();
            for (int k = 0; k < 2; k++) begin
                if (!mact[k] && $urandom_range(1, 0) == 1) begin
                    mact[k] = 1'b1;
                    mop[k] = 2'($urandom_range(3, 1));
                    madr[k] = AW'($urandom);
                    mdat[k] = $urandom;
                    msel[k] = 4'($urandom_range(15, 0));
                    mlck[k] = ($urandom_range(9, 0) < 4);
                end else if (mact[k] && $urandom_range(4, 0) == 0) begin
                    madr[k] = AW'($urandom);
                    mdat[k] = $urandom;
                end
                if (!mact[k]) mop[k] = PINOOP;
            end
            drive_masters();
            s_rdy_i = ($urandom_range(9, 0) < 7);
            s_data_i = $urandom;
            sample();
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
